// File: rtl/morse_sequencer.sv
// rtl/morse_sequencer.sv - Morse letter sequencer (S..Z) with time-unit divider, pattern ROM and start/busy/done handshake
module morse_sequencer #(
    parameter int TICK_DIV  = 25000000,
    parameter int CNT_W     = 25,
    parameter int GAP_UNITS = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] letter,
    input  logic       abort,
    output logic       light,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [3:0]       GAP_INIT = 4'(GAP_UNITS);

    state_t           state, state_nxt;
    logic [13:0]      sr, sr_nxt;
    logic [3:0]       bits_left, bits_nxt;
    logic [3:0]       gap_left, gap_nxt;
    logic [CNT_W-1:0] div, div_nxt;
    logic             done_nxt;
    logic             tick;
    logic [13:0]      rom_pat;
    logic [3:0]       rom_len;

    // Patterns go out LSB first: dot = 1, dash = 111, elements separated by one 0.
    always_comb begin
        rom_pat = 14'b0;
        rom_len = 4'd0;
        case (letter)
            3'b000: begin rom_pat = 14'b00000000010101; rom_len = 4'd5;  end
            3'b001: begin rom_pat = 14'b00000000000111; rom_len = 4'd3;  end
            3'b010: begin rom_pat = 14'b00000001110101; rom_len = 4'd7;  end
            3'b011: begin rom_pat = 14'b00000111010101; rom_len = 4'd9;  end
            3'b100: begin rom_pat = 14'b00000111011101; rom_len = 4'd9;  end
            3'b101: begin rom_pat = 14'b00011101010111; rom_len = 4'd11; end
            3'b110: begin rom_pat = 14'b01110111010111; rom_len = 4'd13; end
            3'b111: begin rom_pat = 14'b00010101110111; rom_len = 4'd11; end
            default: begin rom_pat = 14'b0; rom_len = 4'd0; end
        endcase
    end

    assign tick = (div == DIV_LAST);

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        bits_nxt  = bits_left;
        gap_nxt   = gap_left;
        div_nxt   = div;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    sr_nxt    = rom_pat;
                    bits_nxt  = rom_len;
                    div_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = tick ? '0 : div + CNT_W'(1);
                    if (tick) begin
                        sr_nxt   = {1'b0, sr[13:1]};
                        bits_nxt = bits_left - 4'd1;
                        if (bits_left == 4'd1) begin
                            gap_nxt   = GAP_INIT;
                            state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    div_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = tick ? '0 : div + CNT_W'(1);
                    if (tick) begin
                        gap_nxt = gap_left - 4'd1;
                        if (gap_left == 4'd1) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sr        <= '0;
            bits_left <= '0;
            gap_left  <= '0;
            div       <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= sr_nxt;
            bits_left <= bits_nxt;
            gap_left  <= gap_nxt;
            div       <= div_nxt;
            done      <= done_nxt;
        end
    end

    assign light = (state == SEND) && sr[0];
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_morse_sequencer.sv
// tb/tb_morse_sequencer.sv - scoreboard bench for morse_sequencer, lanes with TICK_DIV=4 and TICK_DIV=1
module tb_morse_sequencer;

    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] start;
    logic [1:0] abort;
    logic [2:0] letter [2];
    logic [1:0] light_w, busy_w, done_w;

    int checks = 0;
    int failures = 0;

    string morse [8] = '{"...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int TD = (g == 0) ? 4 : 1;

        logic [2:0] exp_q [$];
        logic       prev_busy = 1'b0;

        morse_sequencer #(
            .TICK_DIV (TD),
            .CNT_W    (8),
            .GAP_UNITS(GAP)
        ) u_dut (
            .clock  (clock),
            .reset_n(reset_n),
            .start  (start[g]),
            .letter (letter[g]),
            .abort  (abort[g]),
            .light  (light_w[g]),
            .busy   (busy_w[g]),
            .done   (done_w[g])
        );

        task automatic push_letter(input logic [2:0] l);
            string m;
            m = morse[l];
            for (int i = 0; i < m.len(); i++) begin
                if (i > 0) repeat (TD) exp_q.push_back(3'b010);
                if (m[i] == "-") repeat (3 * TD) exp_q.push_back(3'b110);
                else repeat (TD) exp_q.push_back(3'b110);
            end
            repeat (GAP * TD) exp_q.push_back(3'b010);
            exp_q.push_back(3'b001);
        endtask

        always @(posedge clock) begin
            if (!reset_n) exp_q.delete();
            else if (prev_busy) begin
                if (abort[g]) exp_q.delete();
            end else if (start[g] && !abort[g]) begin
                push_letter(letter[g]);
            end
        end

        always @(negedge clock or negedge reset_n) begin
            logic [2:0] e;
            logic [2:0] a;
            if (!reset_n) begin
                #1;
                e = 3'b000;
                prev_busy = 1'b0;
            end else begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
                prev_busy = e[1];
            end
            a = {light_w[g], busy_w[g], done_w[g]};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL lane%0d_outputs t=%0t light/busy/done got=%b required=%b", g, $time, a, e);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        checks++;
        if ({light_w, busy_w, done_w} !== 6'b000000) begin
            failures++;
            $display("FAIL %s t=%0t light=%b busy=%b done=%b required all 0", tag, $time, light_w, busy_w, done_w);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 2'b01;
        abort     = 2'b00;
        letter[0] = 3'b000;
        letter[1] = 3'b000;
        #1;
        check_reset_state("reset_state");
        step(3);
        check_reset_state("reset_state_held");
        reset_n = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(40);

        letter[0] = 3'b110;
        start[0]  = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(70);

        letter[0] = 3'b001;
        start[0]  = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(3);
        letter[0] = 3'b111;
        start[0]  = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(30);

        letter[0] = 3'b010;
        start[0]  = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(9);
        abort[0] = 1'b1;
        step(1);
        abort[0] = 1'b0;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(50);

        for (int i = 0; i < 400; i++) begin
            start[0]  = ($urandom_range(0, 3) == 0);
            letter[0] = 3'($urandom_range(0, 7));
            abort[0]  = ($urandom_range(0, 31) == 0);
            step(1);
        end
        start[0] = 1'b0;
        abort[0] = 1'b0;
        step(80);

        letter[1] = 3'b101;
        start[1]  = 1'b1;
        step(40);
        start[1] = 1'b0;
        step(20);

        for (int i = 0; i < 200; i++) begin
            start[1]  = ($urandom_range(0, 1) == 0);
            letter[1] = 3'($urandom_range(0, 7));
            abort[1]  = ($urandom_range(0, 15) == 0);
            step(1);
        end
        start[1] = 1'b0;
        abort[1] = 1'b0;
        step(30);

        letter[0] = 3'b000;
        start[0]  = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(24);
        reset_n = 1'b0;
        #2;
        check_reset_state("midgap_reset");
        step(2);
        reset_n = 1'b1;
        step(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
